// File: rtl/sinc3_decimator.sv
// Multichannel third-order CIC (sinc3) decimator for 1-bit modulator streams.
// Runtime power-of-two ratio; outputs are normalised to full scale and saturate at R^3.
module sinc3_decimator #(
    parameter int CH         = 2,
    parameter int MAX_R_LOG2 = 8,
    parameter int OUT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CH-1:0]       bits,
    input  logic [3:0]          dec_log2,
    output logic [CH*OUT_W-1:0] out_data,
    output logic                out_valid
);
    localparam int ACC_W  = 3*MAX_R_LOG2 + 1;
    localparam int CNT_W  = MAX_R_LOG2;
    localparam int DROP_W = ACC_W - 1 - OUT_W;
    localparam logic [3:0] MAX_L = 4'(MAX_R_LOG2);
    localparam logic [CNT_W:0] ONE = 1;

    logic [3:0]       clamp_log2;
    logic [3:0]       eff_log2_reg;
    logic [3:0]       shift_diff;
    logic [4:0]       shamt;
    logic             first_reg;
    logic             restart;
    logic             tick;
    logic             settled;
    logic             take;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] r_last;
    logic [CNT_W:0]   r_full;
    logic [2:0]       settle_reg;
    logic             out_valid_reg;
    logic [OUT_W-1:0] out_reg [CH];

    always_comb begin
        clamp_log2 = dec_log2;
        if (dec_log2 == 4'd0) begin
            clamp_log2 = 4'd1;
        end else if (dec_log2 > MAX_L) begin
            clamp_log2 = MAX_L;
        end
    end

    assign r_full  = ONE << eff_log2_reg;
    assign r_last  = CNT_W'(r_full - ONE);
    // first_reg marks the first edge after reset release, where eff_log2 is
    // loaded without treating the difference as a restart.
    assign restart = !first_reg && (clamp_log2 != eff_log2_reg);
    assign tick    = en && !restart && (cnt_reg == r_last);
    assign settled = (settle_reg == 3'd4);
    assign take    = tick && settled;

    // Normalising shift 3*(MAX_R_LOG2 - eff_log2) so R^3 maps to full scale.
    assign shift_diff = MAX_L - eff_log2_reg;
    assign shamt      = {shift_diff, 1'b0} + {1'b0, shift_diff};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eff_log2_reg  <= 4'd1;
            first_reg     <= 1'b1;
            cnt_reg       <= '0;
            settle_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            first_reg     <= 1'b0;
            out_valid_reg <= take;
            if (first_reg || restart) begin
                eff_log2_reg <= clamp_log2;
            end
            if (restart) begin
                cnt_reg    <= '0;
                settle_reg <= '0;
            end else if (en) begin
                cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
                if (tick && !settled) begin
                    settle_reg <= settle_reg + 3'd1;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [ACC_W-1:0] x_ext;
            logic [ACC_W-1:0] i1_reg, i2_reg, i3_reg;
            logic [ACC_W-1:0] d1_reg, d2_reg, d3_reg;
            logic [ACC_W-1:0] c1, c2, c3;
            logic [ACC_W-1:0] n_val;
            logic [OUT_W-1:0] sample;

            assign x_ext  = {{(ACC_W-1){1'b0}}, bits[gi]};
            assign c1     = i3_reg - d1_reg;
            assign c2     = c1 - d2_reg;
            assign c3     = c2 - d3_reg;
            assign n_val  = c3 << shamt;
            // Only y = R^3 reaches the top bit; clip it to all-ones.
            assign sample = n_val[ACC_W-1] ? {OUT_W{1'b1}} : OUT_W'(n_val >> DROP_W);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    i1_reg      <= '0;
                    i2_reg      <= '0;
                    i3_reg      <= '0;
                    d1_reg      <= '0;
                    d2_reg      <= '0;
                    d3_reg      <= '0;
                    out_reg[gi] <= '0;
                end else if (restart) begin
                    i1_reg <= '0;
                    i2_reg <= '0;
                    i3_reg <= '0;
                    d1_reg <= '0;
                    d2_reg <= '0;
                    d3_reg <= '0;
                end else if (en) begin
                    i1_reg <= i1_reg + x_ext;
                    i2_reg <= i2_reg + i1_reg;
                    i3_reg <= i3_reg + i2_reg;
                    if (tick) begin
                        d1_reg <= i3_reg;
                        d2_reg <= c1;
                        d3_reg <= c2;
                    end
                    if (take) begin
                        out_reg[gi] <= sample;
                    end
                end
            end

            assign out_data[gi*OUT_W +: OUT_W] = out_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sinc3_decimator.sv
// Bench for sinc3_decimator: vector table with spec constants, restart/reset sequences,
// and randomized traffic against a direct-convolution reference model.
module tb_sinc3_decimator;
    localparam int CH = 2;
    localparam int MR = 4;
    localparam int OW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [CH-1:0]  bits = '0;
    logic [3:0]     dec_log2 = 4'd2;
    logic [CH*OW-1:0] out_data;
    logic           out_valid;

    always #5 clk = ~clk;

    sinc3_decimator #(.CH(CH), .MAX_R_LOG2(MR), .OUT_W(OW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bits(bits), .dec_log2(dec_log2),
        .out_data(out_data), .out_valid(out_valid)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: bit history since the last restart.
    logic [CH-1:0] hist[$];
    int   m_cnt;
    int   m_eff;
    bit   m_first;
    logic m_valid;
    logic [OW-1:0] m_data [CH];

    int edge_idx, first_valid_edge, last_valid_edge, spacing;
    logic [CH*OW-1:0] last_valid_data;

    typedef struct {
        int dec; int en_per;
        int p0; int l0; int p1; int l1;
        int ncyc; int first_edge; int spacing; int ch0; int ch1;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic int clampf(input int d);
        if (d == 0) return 1;
        if (d > MR) return MR;
        return d;
    endfunction

    // y = sum over a,b,c in [0,R) of x[t-3-a-b-c]: three length-R boxcars
    // plus the three register delays of the integrator chain.
    function automatic int ymodel(input int ch, input int t, input int r);
        int s = 0;
        for (int a = 0; a < r; a++)
            for (int b = 0; b < r; b++)
                for (int c = 0; c < r; c++) begin
                    int idx = t - 3 - a - b - c;
                    if (idx >= 0 && hist[idx][ch]) s++;
                end
        return s;
    endfunction

    task automatic model_edge(input logic e, input logic [CH-1:0] b, input logic [3:0] d);
        int r, y, n;
        m_valid = 1'b0;
        if (m_first) begin
            m_first = 1'b0;
            m_eff = clampf(int'(d));
        end else if (clampf(int'(d)) != m_eff) begin
            hist.delete();
            m_cnt = 0;
            m_eff = clampf(int'(d));
            return;
        end
        if (e) begin
            hist.push_back(b);
            m_cnt++;
            r = 1 << m_eff;
            if (m_cnt % r == 0 && m_cnt / r >= 5) begin
                m_valid = 1'b1;
                for (int c = 0; c < CH; c++) begin
                    y = ymodel(c, m_cnt - 1, r);
                    n = y << (3 * (MR - m_eff));
                    m_data[c] = (n >= 4096) ? 8'hFF : OW'((n >> 4) & 255);
                end
            end
        end
    endtask

    task automatic step(input logic e, input logic [CH-1:0] b, input logic [3:0] d);
        @(negedge clk);
        en = e; bits = b; dec_log2 = d;
        @(posedge clk);
        model_edge(e, b, d);
        #1;
        edge_idx++;
        check("out_valid", int'(out_valid), int'(m_valid));
        check("out_data", int'(out_data), int'({m_data[1], m_data[0]}));
        if (out_valid) begin
            if (first_valid_edge < 0) first_valid_edge = edge_idx;
            else spacing = edge_idx - last_valid_edge;
            last_valid_edge = edge_idx;
            last_valid_data = out_data;
        end
    endtask

    task automatic apply_reset(input logic [3:0] d);
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; dec_log2 = d;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        hist.delete();
        m_cnt = 0; m_first = 1'b1; m_valid = 1'b0;
        for (int c = 0; c < CH; c++) m_data[c] = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        edge_idx = -1; first_valid_edge = -1; last_valid_edge = -1; spacing = -1;
        last_valid_data = '0;
    endtask

    initial begin
        int j, nv;
        logic [3:0] d;
        logic e;
        logic [CH-1:0] b;

        vecs[0] = '{2, 1, 1, 1, 0, 1,  60, 19,  4, 255,   0};
        vecs[1] = '{2, 1, 1, 2, 1, 1,  60, 19,  4, 128, 255};
        vecs[2] = '{4, 1, 7, 4, 1, 2, 144, 79, 16, 192, 128};
        vecs[3] = '{1, 3, 1, 1, 1, 2,  60, 27,  6, 255, 128};
        vecs[4] = '{0, 1, 1, 1, 0, 1,  30,  9,  2, 255,   0};
        vecs[5] = '{15, 1, 7, 4, 1, 1, 144, 79, 16, 192, 255};

        // Each vector starts with a reset that lands mid-decimation of the previous one.
        foreach (vecs[i]) begin
            apply_reset(4'(vecs[i].dec));
            j = 0;
            for (int cyc = 0; cyc < vecs[i].ncyc; cyc++) begin
                e = (cyc % vecs[i].en_per) == 0;
                if (e) begin
                    b[0] = ((vecs[i].p0 >> (j % vecs[i].l0)) & 1) != 0;
                    b[1] = ((vecs[i].p1 >> (j % vecs[i].l1)) & 1) != 0;
                    j++;
                end else begin
                    b = CH'($urandom);
                end
                step(e, b, 4'(vecs[i].dec));
            end
            check($sformatf("v%0d_first_valid", i), first_valid_edge, vecs[i].first_edge);
            check($sformatf("v%0d_spacing", i), spacing, vecs[i].spacing);
            check($sformatf("v%0d_ch0", i), int'(last_valid_data[7:0]), vecs[i].ch0);
            check($sformatf("v%0d_ch1", i), int'(last_valid_data[15:8]), vecs[i].ch1);
        end

        // Ratio change 2 -> 3 mid-stream: 40 quiet en cycles, then R=8 output.
        apply_reset(4'd2);
        for (int k = 0; k < 30; k++) step(1'b1, CH'($urandom), 4'd2);
        step(1'b1, CH'($urandom), 4'd3);
        nv = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, CH'($urandom), 4'd3);
            if (k < 40 && out_valid) nv++;
        end
        check("restart_quiet", nv, 0);
        check("restart_first_valid", int'(out_valid), 1);
        for (int k = 0; k < 40; k++) step(1'b1, CH'($urandom), 4'd3);

        // Reset mid-decimation with a freeze in progress.
        for (int k = 0; k < 6; k++) step(1'b0, CH'($urandom), 4'd3);
        apply_reset(4'd3);
        for (int k = 0; k < 45; k++) step(1'b1, 2'b11, 4'd3);
        check("post_reset_first_valid", first_valid_edge, 39);
        check("post_reset_full_scale", int'(last_valid_data), 16'hFFFF);

        // Randomized traffic with sporadic ratio changes.
        apply_reset(4'd2);
        d = 4'd2;
        for (int k = 0; k < 900; k++) begin
            if ($urandom_range(0, 199) == 0) d = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 3) != 0), CH'($urandom), d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sinc3_decimator.md
SINC3_DECIMATOR -- requirements
Module: sinc3_decimator

Interface
REQ-001 SHALL have parameter CH, default 2: number of independent 1-bit modulator channels (1..8).
REQ-002 SHALL have parameter MAX_R_LOG2, default 8: log2 of the largest supported decimation ratio (1..10).
REQ-003 SHALL have parameter OUT_W, default 16: output sample width per channel; legal only if OUT_W <= ACC_W-1, where ACC_W = 3*MAX_R_LOG2+1.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic; no secondary decimated clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port en, input, 1 bit: modulator bit strobe; each cycle with en=1 consumes one bit per channel.
REQ-007 SHALL have port bits, input, CH bits: bit c is the modulator stream for channel c.
REQ-008 SHALL have port dec_log2, input, 4 bits: runtime decimation ratio R = 2^dec_log2.
REQ-009 SHALL have port out_data, output, CH*OUT_W bits: channel c occupies bits [c*OUT_W +: OUT_W].
REQ-010 SHALL have port out_valid, output, 1 bit: one-cycle strobe qualifying out_data for all channels.

Function
REQ-011 SHALL map an input bit of 1 to +1 and 0 to 0 (unipolar), identically for every channel.
REQ-012 SHALL use, per channel, three cascaded ACC_W-bit registered integrators updated only on cycles with en=1, wrapping modulo 2^ACC_W.
REQ-013 SHALL keep an effective-ratio register eff_log2, equal to dec_log2 clamped to 1 when 0 and to MAX_R_LOG2 when above it.
REQ-014 SHALL run a decimation counter 0..R-1 that advances only on en=1 cycles; a tick occurs on the en=1 cycle where the count equals R-1, and the counter then wraps to 0.
REQ-015 SHALL, on the clock edge ending a tick cycle, pass the third-integrator register value through three ACC_W-bit comb (differentiator) stages with one-sample delay registers, all modulo 2^ACC_W.
REQ-016 SHALL compute the same edge's comb result y (range 0..R^3), form n = y << 3*(MAX_R_LOG2-eff_log2), and register out_data = n[ACC_W-2 -: OUT_W], or all-ones if n[ACC_W-1] is set (full scale saturates).
REQ-017 SHALL assert out_valid for exactly the one cycle following the tick edge, and only after the settling count is satisfied.
REQ-018 SHALL hold out_data stable between valid strobes.
REQ-019 SHALL discard (not flag valid) the first 4 ticks after reset or restart; the 5th and later ticks produce valid outputs.
REQ-020 SHALL treat en=0 as a full freeze: integrators, counter, combs and out_data hold, and out_valid stays 0.
REQ-021 SHALL restart when the clamped value of dec_log2 differs from eff_log2 on any cycle, with priority over a coincident tick, by doing all of the following at that edge:
- clear integrators, combs, decimation counter and settle count;
- load eff_log2 with the new clamped value;
- drive out_valid 0;
- hold out_data.
REQ-022 SHALL process all channels in lockstep; a single decimation counter and settle count serve all channels.
REQ-023 SHALL never produce wrong results from integrator wrap: CIC modular arithmetic guarantees an exact y for y <= R^3 < 2^ACC_W.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear all integrators, combs, counters and settle count, set out_data=0 and out_valid=0, and set eff_log2 to the clamped dec_log2 sampled at the first clock edge after release.
REQ-025 SHALL abandon any in-flight decimation when reset asserts mid-operation; the first valid output after release is the 5th tick.

Verification (CH=2, MAX_R_LOG2=4, OUT_W=8, ACC_W=13)
REQ-026 SHALL cover: dec_log2=2, en=1 continuously, bits=2'b01 from reset -> first out_valid on the cycle after the 20th en cycle; ch0=0xFF, ch1=0x00; thereafter out_valid every 4 cycles.
REQ-027 SHALL cover: dec_log2=2, ch0 toggling 1,0,1,0 -> every valid ch0 sample = 0x80 (y=32, n=2048).
REQ-028 SHALL cover: dec_log2=4, ch0 pattern 1,1,1,0 repeating -> valid ch0 = 0xC0 (y=3072); valid spacing 16 en cycles.
REQ-029 SHALL cover: en asserted only every 3rd cycle, dec_log2=1 -> outputs identical to the continuous-en run, with valid spacing 6 clk cycles.
REQ-030 SHALL cover: dec_log2 changed 2 -> 3 mid-stream -> no out_valid for the next 5*8 en cycles, then correct R=8 values.
REQ-031 SHALL cover: rst_n pulsed low mid-decimation, and dec_log2=0 or 15 -> immediate out_data=0 and out_valid=0; R clamps to 2 and 16 respectively.
